// File: rtl/cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_seq
// Instruction sequencer for the 4-bit microprocessor. Runs a six-T-state
// fetch/execute ring and decodes the opcode nibble into the per-cycle control
// word for the PC, MAR, memory, IR, accumulator, B register, ALU and output
// register, all of which share one 8-bit bus.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset (overrides every state, incl. HALT)
//   run        sequencing enable, sampled in IDLE and T6
//   opcode     IR[7:4], meaningful in T4..T6
//   zero_flag  accumulator zero flag, used in T4 of JZ
//   pc_oen / mem_oen / ir_oen / acc_oen / alu_oen   active-low bus drivers
//   pc_inc, load_pc, mar_load, ir_load, acc_load, b_load, out_load, alu_sub
//   halted     high in HALT
//   tstate     IDLE=0, T1..T6=1..6, HALT=7
//
// The state is registered; the control word is decoded combinationally from
// the state, the opcode and zero_flag. It cannot be registered: the IR is
// loaded on the edge that starts T4, and zero_flag must be seen live in T4.
// ---------------------------------------------------------------------------
module cpu_ctrl_seq #(
   parameter int unsigned OP_W = 4
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            run,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero_flag,
   output logic            pc_oen,
   output logic            pc_inc,
   output logic            load_pc,
   output logic            mar_load,
   output logic            mem_oen,
   output logic            ir_load,
   output logic            ir_oen,
   output logic            acc_load,
   output logic            b_load,
   output logic            out_load,
   output logic            acc_oen,
   output logic            alu_oen,
   output logic            alu_sub,
   output logic            halted,
   output logic [2:0]      tstate
);

   localparam int unsigned TS_W = 3;

   // State encoding equals the externally visible tstate value.
   typedef enum logic [TS_W-1:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_T5   = 3'd5,
      ST_T6   = 3'd6,
      ST_HALT = 3'd7
   } state_t;

   localparam logic [OP_W-1:0] OPC_NOP = OP_W'(4'h0);
   localparam logic [OP_W-1:0] OPC_LDA = OP_W'(4'h1);
   localparam logic [OP_W-1:0] OPC_ADD = OP_W'(4'h2);
   localparam logic [OP_W-1:0] OPC_SUB = OP_W'(4'h3);
   localparam logic [OP_W-1:0] OPC_OUT = OP_W'(4'h5);
   localparam logic [OP_W-1:0] OPC_JMP = OP_W'(4'h6);
   localparam logic [OP_W-1:0] OPC_JZ  = OP_W'(4'h7);
   localparam logic [OP_W-1:0] OPC_HLT = OP_W'(4'hF);

   state_t r_state;

   // Opcode class decodes, only meaningful while the state is T4..T6.
   logic w_is_lda;
   logic w_is_add;
   logic w_is_sub;
   logic w_is_out;
   logic w_is_jmp;
   logic w_is_jz;
   logic w_is_hlt;
   logic w_is_nop;

   always_comb begin
      w_is_lda = (opcode == OPC_LDA);
      w_is_add = (opcode == OPC_ADD);
      w_is_sub = (opcode == OPC_SUB);
      w_is_out = (opcode == OPC_OUT);
      w_is_jmp = (opcode == OPC_JMP);
      w_is_jz  = (opcode == OPC_JZ);
      w_is_hlt = (opcode == OPC_HLT);
      w_is_nop = (opcode == OPC_NOP);
   end

   // State register with next-state logic; clr wins over every state.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: r_state <= run ? ST_T1 : ST_IDLE;
            ST_T1:   r_state <= ST_T2;
            ST_T2:   r_state <= ST_T3;
            ST_T3:   r_state <= ST_T4;
            ST_T4:   r_state <= w_is_hlt ? ST_HALT : ST_T5;
            ST_T5:   r_state <= ST_T6;
            ST_T6:   r_state <= run ? ST_T1 : ST_IDLE;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Control word decode. Defaults form the inactive word, so IDLE, HALT,
   // HLT's T4 and every unlisted opcode/T-state pair fall through to it.
   // At most one active-low bus driver is asserted in any arm.
   always_comb begin
      pc_oen   = 1'b1;
      mem_oen  = 1'b1;
      ir_oen   = 1'b1;
      acc_oen  = 1'b1;
      alu_oen  = 1'b1;
      pc_inc   = 1'b0;
      load_pc  = 1'b0;
      mar_load = 1'b0;
      ir_load  = 1'b0;
      acc_load = 1'b0;
      b_load   = 1'b0;
      out_load = 1'b0;
      alu_sub  = 1'b0;

      unique case (r_state)
         // Fetch: PC -> MAR, PC++, MEM -> IR.
         ST_T1: begin
            pc_oen   = 1'b0;
            mar_load = 1'b1;
         end
         ST_T2: begin
            pc_inc = 1'b1;
         end
         ST_T3: begin
            mem_oen = 1'b0;
            ir_load = 1'b1;
         end
         // Execute step 1: operand address to MAR, ACC to OUT, or jump target to PC.
         ST_T4: begin
            if (w_is_lda || w_is_add || w_is_sub) begin
               ir_oen   = 1'b0;
               mar_load = 1'b1;
            end else if (w_is_out) begin
               acc_oen  = 1'b0;
               out_load = 1'b1;
            end else if (w_is_jmp || (w_is_jz && zero_flag)) begin
               ir_oen  = 1'b0;
               load_pc = 1'b1;
            end
         end
         // Execute step 2: memory operand into ACC (LDA) or B (ADD/SUB).
         ST_T5: begin
            if (w_is_lda) begin
               mem_oen  = 1'b0;
               acc_load = 1'b1;
            end else if (w_is_add || w_is_sub) begin
               mem_oen = 1'b0;
               b_load  = 1'b1;
            end
         end
         // Execute step 3: ALU result back into ACC.
         ST_T6: begin
            if (w_is_add || w_is_sub) begin
               alu_oen  = 1'b0;
               acc_load = 1'b1;
               alu_sub  = w_is_sub;
            end
         end
         default: begin
         end
      endcase
   end

   // Status outputs follow the state directly.
   always_comb begin
      halted = (r_state == ST_HALT);
      tstate = TS_W'(r_state);
   end

   // w_is_nop is kept for readability of the decode table; NOP has no actions.
   logic w_unused;
   always_comb w_unused = w_is_nop;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_seq
// Directed bench for cpu_ctrl_seq. Each cycle the stimulus block drives the
// inputs and pushes the control word expected for that cycle; a checker pops
// it on the falling edge and compares, and also checks bus exclusivity.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_seq;

   typedef struct packed {
      logic [2:0] ts;
      logic       halted;
      logic       pc_oen;
      logic       pc_inc;
      logic       load_pc;
      logic       mar_load;
      logic       mem_oen;
      logic       ir_load;
      logic       ir_oen;
      logic       acc_load;
      logic       b_load;
      logic       out_load;
      logic       acc_oen;
      logic       alu_oen;
      logic       alu_sub;
   } cw_t;

   logic       clk;
   logic       clr;
   logic       run;
   logic [3:0] opcode;
   logic       zero_flag;
   logic       pc_oen, pc_inc, load_pc, mar_load, mem_oen, ir_load, ir_oen;
   logic       acc_load, b_load, out_load, acc_oen, alu_oen, alu_sub, halted;
   logic [2:0] tstate;

   cw_t sb[$];
   int  errors = 0;
   int  checks = 0;
   int  cycle  = 0;

   cpu_ctrl_seq #(.OP_W(4)) dut (
      .clk       (clk),
      .clr       (clr),
      .run       (run),
      .opcode    (opcode),
      .zero_flag (zero_flag),
      .pc_oen    (pc_oen),
      .pc_inc    (pc_inc),
      .load_pc   (load_pc),
      .mar_load  (mar_load),
      .mem_oen   (mem_oen),
      .ir_load   (ir_load),
      .ir_oen    (ir_oen),
      .acc_load  (acc_load),
      .b_load    (b_load),
      .out_load  (out_load),
      .acc_oen   (acc_oen),
      .alu_oen   (alu_oen),
      .alu_sub   (alu_sub),
      .halted    (halted),
      .tstate    (tstate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inactive control word for a given T-state.
   function automatic cw_t idle_w(input logic [2:0] ts);
      cw_t w;
      w         = '0;
      w.ts      = ts;
      w.halted  = (ts == 3'd7);
      w.pc_oen  = 1'b1;
      w.mem_oen = 1'b1;
      w.ir_oen  = 1'b1;
      w.acc_oen = 1'b1;
      w.alu_oen = 1'b1;
      return w;
   endfunction

   // Queue the expected word for the current cycle, then advance one clock.
   task automatic step(input cw_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Fetch with a junk opcode on the IR to show fetch ignores it.
   task automatic fetch();
      cw_t e;
      opcode = 4'hF;
      e = idle_w(3'd1); e.pc_oen = 1'b0; e.mar_load = 1'b1; step(e);
      e = idle_w(3'd2); e.pc_inc = 1'b1;                    step(e);
      e = idle_w(3'd3); e.mem_oen = 1'b0; e.ir_load = 1'b1; step(e);
   endtask

   // Checker: compare the queued word and the bus-exclusion rule every cycle.
   always @(negedge clk) begin
      cycle++;
      if (sb.size() != 0) begin
         cw_t e;
         cw_t o;
         e = sb.pop_front();
         o = {tstate, halted, pc_oen, pc_inc, load_pc, mar_load, mem_oen,
              ir_load, ir_oen, acc_load, b_load, out_load, acc_oen, alu_oen, alu_sub};
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL ctrl_word cycle=%0d observed=%h expected=%h", cycle, o, e);
         end
         checks++;
         assert ($countones({~pc_oen, ~mem_oen, ~ir_oen, ~acc_oen, ~alu_oen}) <= 1) else begin
            errors++;
            $error("FAIL bus_excl cycle=%0d observed_oen=%b expected=at_most_one_low", cycle,
                   {pc_oen, mem_oen, ir_oen, acc_oen, alu_oen});
         end
      end
   end

   initial begin
      cw_t e;
      clr = 1'b1; run = 1'b0; opcode = 4'h0; zero_flag = 1'b0;
      @(posedge clk);
      #1;
      // Reset, second clr cycle, then 10 idle cycles with run low.
      step(idle_w(3'd0));
      clr = 1'b0;
      for (int i = 0; i < 10; i++) step(idle_w(3'd0));
      run = 1'b1;
      step(idle_w(3'd0));

      // ADD
      fetch();
      opcode = 4'h2;
      e = idle_w(3'd4); e.ir_oen  = 1'b0; e.mar_load = 1'b1; step(e);
      e = idle_w(3'd5); e.mem_oen = 1'b0; e.b_load   = 1'b1; step(e);
      e = idle_w(3'd6); e.alu_oen = 1'b0; e.acc_load = 1'b1; step(e);

      // SUB immediately after (no bubble)
      fetch();
      opcode = 4'h3;
      e = idle_w(3'd4); e.ir_oen  = 1'b0; e.mar_load = 1'b1; step(e);
      e = idle_w(3'd5); e.mem_oen = 1'b0; e.b_load   = 1'b1; step(e);
      e = idle_w(3'd6); e.alu_oen = 1'b0; e.acc_load = 1'b1; e.alu_sub = 1'b1; step(e);

      // LDA with run dropped in T3: completes, then IDLE
      e = idle_w(3'd1); e.pc_oen = 1'b0; e.mar_load = 1'b1; step(e);
      e = idle_w(3'd2); e.pc_inc = 1'b1;                    step(e);
      run = 1'b0;
      e = idle_w(3'd3); e.mem_oen = 1'b0; e.ir_load = 1'b1; step(e);
      opcode = 4'h1;
      e = idle_w(3'd4); e.ir_oen  = 1'b0; e.mar_load = 1'b1; step(e);
      e = idle_w(3'd5); e.mem_oen = 1'b0; e.acc_load = 1'b1; step(e);
      step(idle_w(3'd6));
      step(idle_w(3'd0));
      run = 1'b1;
      step(idle_w(3'd0));

      // JZ not taken; zero_flag rising in T5 has no effect
      fetch();
      opcode = 4'h7; zero_flag = 1'b0;
      step(idle_w(3'd4));
      zero_flag = 1'b1;
      step(idle_w(3'd5));
      step(idle_w(3'd6));

      // JZ taken; zero_flag falling in T5 has no effect
      fetch();
      opcode = 4'h7; zero_flag = 1'b1;
      e = idle_w(3'd4); e.ir_oen = 1'b0; e.load_pc = 1'b1; step(e);
      zero_flag = 1'b0;
      step(idle_w(3'd5));
      step(idle_w(3'd6));

      // OUT
      fetch();
      opcode = 4'h5;
      e = idle_w(3'd4); e.acc_oen = 1'b0; e.out_load = 1'b1; step(e);
      step(idle_w(3'd5));
      step(idle_w(3'd6));

      // JMP
      fetch();
      opcode = 4'h6;
      e = idle_w(3'd4); e.ir_oen = 1'b0; e.load_pc = 1'b1; step(e);
      step(idle_w(3'd5));
      step(idle_w(3'd6));

      // Unlisted opcode behaves as NOP
      fetch();
      opcode = 4'h9; zero_flag = 1'b1;
      step(idle_w(3'd4));
      step(idle_w(3'd5));
      step(idle_w(3'd6));
      zero_flag = 1'b0;

      // ADD with clr in T5: control word still shown, then IDLE with no loads
      fetch();
      opcode = 4'h2;
      e = idle_w(3'd4); e.ir_oen  = 1'b0; e.mar_load = 1'b1; step(e);
      clr = 1'b1;
      e = idle_w(3'd5); e.mem_oen = 1'b0; e.b_load   = 1'b1; step(e);
      clr = 1'b0; run = 1'b0;
      step(idle_w(3'd0));
      run = 1'b1;
      step(idle_w(3'd0));

      // HLT: no T5/T6, HALT holds against run toggling, clr releases
      fetch();
      opcode = 4'hF;
      step(idle_w(3'd4));
      opcode = 4'h2;
      for (int i = 0; i < 20; i++) begin
         run = ~run;
         step(idle_w(3'd7));
      end
      clr = 1'b1; run = 1'b0;
      step(idle_w(3'd7));
      clr = 1'b0;
      step(idle_w(3'd0));
      step(idle_w(3'd0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Instruction sequencer for the 4-bit microprocessor. It generates the per-cycle control word that drives the program counter (`pc_oen`, `pc_inc`, `load_pc`), memory address register, memory, instruction register, accumulator, B register, ALU and output register. It runs a fixed six-T-state fetch/execute ring, decoded from the opcode nibble, and sits between the instruction register and every datapath block on the shared 8-bit bus.

## Interface
Parameters:
- `OP_W`, 4, opcode width (instruction register bits [7:4]).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `run`  in  1  sequencing enable, sampled only in IDLE and T6.
- `opcode`  in  OP_W  current instruction register opcode; used only in T4–T6.
- `zero_flag`  in  1  accumulator zero flag; used only in T4 of JZ.
- `pc_oen`  out  1  PC-to-bus enable, active-low.
- `pc_inc`  out  1  PC increment.
- `load_pc`  out  1  PC load from bus.
- `mar_load`  out  1  MAR load from bus.
- `mem_oen`  out  1  memory-to-bus enable, active-low.
- `ir_load`  out  1  IR load from bus.
- `ir_oen`  out  1  IR operand (low nibble, zero-extended) to bus, active-low.
- `acc_load`, `b_load`, `out_load`  out  1 each  register loads.
- `acc_oen`, `alu_oen`  out  1 each  bus enables, active-low.
- `alu_sub`  out  1  ALU mode: 1 = subtract, 0 = add.
- `halted`  out  1  high in HALT.
- `tstate`  out  3  IDLE=0, T1..T6=1..6, HALT=7.

## Operation
- States: IDLE, T1–T6, HALT. The state is registered. Outputs are combinationally decoded from the state, the opcode and `zero_flag`.
- Inactive control word: all `*_oen`=1, all other controls 0. This word is used in IDLE, HALT, and any T-state with no listed action.
- Transitions:
  - IDLE→T1 if `run`=1, else stay in IDLE.
  - T1→…→T6 unconditionally.
  - T6→T1 if `run`=1, else IDLE.
  - T4→HALT if opcode=4'hF.
  - HALT holds until `clr`.
- Fetch, the same for every opcode:
  - T1: `pc_oen`=0, `mar_load`=1.
  - T2: `pc_inc`=1.
  - T3: `mem_oen`=0, `ir_load`=1.
- Execute, T4/T5/T6:
  - 0 NOP: none/none/none.
  - 1 LDA: `ir_oen`=0+`mar_load` / `mem_oen`=0+`acc_load` / none.
  - 2 ADD: `ir_oen`=0+`mar_load` / `mem_oen`=0+`b_load` / `alu_oen`=0+`acc_load`.
  - 3 SUB: same as ADD, plus `alu_sub`=1 in T6 only.
  - 5 OUT: `acc_oen`=0+`out_load` / none / none.
  - 6 JMP: `ir_oen`=0+`load_pc` / none / none.
  - 7 JZ: in T4, if `zero_flag`=1 then `ir_oen`=0+`load_pc`, else none.
  - F HLT: T4 emits the inactive word, then the state goes to HALT.
  - All other opcodes execute as NOP.
- Bus rule: at most one of `pc_oen`, `mem_oen`, `ir_oen`, `acc_oen`, `alu_oen` is low in any cycle.
- `run` deasserted mid-instruction: the instruction completes through T6, then the state goes to IDLE.
- `clr` overrides everything, including HALT and mid-instruction states.

## Timing
- Reset: on the first edge with `clr`=1, the state goes to IDLE. Outputs are then the inactive word, with `halted`=0 and `tstate`=0.
- Each control is asserted for the whole cycle of its T-state. The target register captures on the rising edge that ends that cycle.
- Instruction period: exactly 6 clocks for all non-HLT opcodes. Back-to-back instructions have no bubble while `run`=1.
- First T1 occurs one cycle after `run` is seen high in IDLE.
- `opcode` must be stable from the edge ending T3 through T6. The IR is loaded at the end of T3.
- `zero_flag` is sampled combinationally during T4 only. A change in T5/T6 has no effect.
- HLT: `halted`=1 and `tstate`=7 from the cycle after T4. No T5/T6 is emitted for HLT.
- `clr` in any state produces IDLE on the next cycle. Loads in that cycle are 0.

## Test plan
- Reset/idle: `clr`=1 for 2 cycles, `run`=0 → `tstate`=0, all `*_oen`=1, all loads 0; held for 10 cycles.
- Fetch: `run`=1 after reset → `tstate` 1,2,3 on the next three cycles:
  - T1: `pc_oen`=0, `mar_load`=1.
  - T2: `pc_inc`=1.
  - T3: `mem_oen`=0, `ir_load`=1.
  - Check that no other control is active in these cycles.
- ADD then SUB (`opcode`=2, then 3):
  - ADD T4: `ir_oen`=0, `mar_load`=1.
  - ADD T5: `mem_oen`=0, `b_load`=1.
  - ADD T6: `alu_oen`=0, `acc_load`=1, `alu_sub`=0.
  - SUB: identical, except `alu_sub`=1 in T6 only.
  - Next T1 follows immediately, with no bubble.
- JZ (`opcode`=7):
  - `zero_flag`=0 → T4 inactive, `load_pc`=0.
  - `zero_flag`=1 → T4 `ir_oen`=0, `load_pc`=1.
  - `zero_flag` toggled in T5 → no effect.
- HLT (`opcode`=F) → cycle after T4 `halted`=1, `tstate`=7, all inactive; `run` toggled 20 cycles with no change; `clr` pulse → `tstate`=0, `halted`=0.
- Mid-operation:
  - `clr` asserted in T5 of ADD → next cycle IDLE, `b_load`=0.
  - `run` dropped in T3 of LDA → LDA completes through T6, then `tstate`=0.
  - Bus-exclusion assertion checked on every cycle.
